instr_fetch: RTL and testbench

Automatic instruction fetch sequencer that sits directly upstream of the processor's `DIN` input. It replaces the manual two-key ROM stepping with an address counter, a synchronous-ROM read sequence and a valid/ready word handshake. It also flags the immediate word that follows every `mvi` (opcode `01`) so the consumer never decodes data as an instruction. The block supports free-run and single-step modes.

---
 rtl/instr_fetch_pkg.sv | 14 +
 rtl/instr_fetch_if.sv | 11 +
 rtl/instr_fetch_edge_detect.sv | 19 +
 rtl/instr_fetch.sv | 78 +++++++
 tb/tb_instr_fetch.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/instr_fetch_pkg.sv
// fetch_pkg: shared FSM state type, opcode constants and opcode field position helpers
package fetch_pkg;
    typedef enum logic [2:0] {IDLE, REQ, CAP, PRESENT, HALT} state_t;
    localparam logic [1:0] OP_MV  = 2'b00;
    localparam logic [1:0] OP_MVI = 2'b01;
    localparam logic [1:0] OP_ADD = 2'b10;
    localparam logic [1:0] OP_SUB = 2'b11;
    function automatic int op_hi(int dw);
        return dw - 1;
    endfunction
    function automatic int op_lo(int dw);
        return dw - 2;
    endfunction
endpackage

// File: rtl/instr_fetch_if.sv
// instr_fetch_if: ROM read bus plus the DIN valid/ready word handshake
interface instr_fetch_if #(parameter int ADDR_W = 5, parameter int DATA_W = 8);
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_q;
    logic [DATA_W-1:0] DIN;
    logic              din_valid;
    logic              din_ready;
    logic              Imm;
    modport master (output rom_addr, DIN, din_valid, Imm, input rom_q, din_ready);
    modport slave  (input rom_addr, DIN, din_valid, Imm, output rom_q, din_ready);
endinterface

// File: rtl/instr_fetch_edge_detect.sv
// edge_detect: registered rising-edge pulse for the debounced Step key
module edge_detect (
    input  logic Clock,
    input  logic Reset,
    input  logic d,
    output logic rise
);
    logic prev;
    // remember last level and emit a one-cycle pulse on 0->1
    always_ff @(posedge Clock) begin
        if (Reset) begin
            prev <= 1'b0;
            rise <= 1'b0;
        end else begin
            prev <= d;
            rise <= d & ~prev;
        end
    end
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: ROM fetch sequencer with DIN handshake and mvi immediate tagging (FETCH_WRAP_EN: wrap to 0 instead of halting)
module instr_fetch
    import fetch_pkg::*;
#(
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 8,
    parameter int PROG_LEN = 32
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Run,
    input  logic              Step,
    instr_fetch_if.master     bus,
    output logic [ADDR_W-1:0] PC,
    output logic              Done
);
    localparam int OH = op_hi(DATA_W);
    localparam int OL = op_lo(DATA_W);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(PROG_LEN - 1);

    state_t            state, state_n;
    logic [ADDR_W-1:0] pc_n;
    logic              token, token_n, imm_pending, rise, last, go;

    edge_detect u_step (.Clock(Clock), .Reset(Reset), .d(Step), .rise(rise));

    assign last          = PC == LAST;
    assign go            = Run | token;
    assign bus.din_valid = state == PRESENT;
    assign Done          = state == HALT;

    // next state, next PC and step token; Run masks step edges
    always_comb begin
        state_n = state;
        pc_n    = PC;
        token_n = (state == IDLE && rise && !Run) ? 1'b1 : token;
        case (state)
            IDLE:    state_n = go ? REQ : IDLE;
            REQ:     state_n = CAP;
            CAP:     state_n = PRESENT;
            PRESENT: if (bus.din_ready) begin
                token_n = 1'b0;
`ifdef FETCH_WRAP_EN
                pc_n    = last ? '0 : PC + 1'b1;
                state_n = Run ? REQ : IDLE;
`else
                pc_n    = last ? PC : PC + 1'b1;
                state_n = last ? HALT : (Run ? REQ : IDLE);
`endif
            end
            HALT:    state_n = HALT;
            default: state_n = IDLE;
        endcase
    end

    // state, address and captured word; immediates never re-arm imm_pending
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state        <= IDLE;
            PC           <= '0;
            bus.rom_addr <= '0;
            bus.DIN      <= '0;
            bus.Imm      <= 1'b0;
            token        <= 1'b0;
            imm_pending  <= 1'b0;
        end else begin
            state        <= state_n;
            PC           <= pc_n;
            bus.rom_addr <= pc_n;
            token        <= token_n;
            if (state == CAP) begin
                bus.DIN     <= bus.rom_q;
                bus.Imm     <= imm_pending;
                imm_pending <= (bus.rom_q[OH:OL] == OP_MVI) && !imm_pending;
            end
        end
    end
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed tests with a word-level delivery model checked every cycle
module tb_instr_fetch;
    localparam int PL = 4;
`ifdef FETCH_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic       Run   = 1'b0;
    logic       Step  = 1'b0;
    logic [4:0] PC;
    logic       Done;
    logic [7:0] rom [32];
    logic [8:0] lg [$];
    int         n_cmp = 0, n_err = 0;
    int         m_pc = 0;
    bit         m_imm = 0, m_done = 0, armed = 0;

    instr_fetch_if #(.ADDR_W(5), .DATA_W(8)) bus ();

    instr_fetch #(.ADDR_W(5), .DATA_W(8), .PROG_LEN(PL)) dut (
        .Clock(Clock), .Reset(Reset), .Run(Run), .Step(Step),
        .bus(bus), .PC(PC), .Done(Done)
    );

    always #5 Clock = ~Clock;

    // synchronous ROM
    always @(posedge Clock) bus.rom_q <= rom[bus.rom_addr];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge Clock);
        #1;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        tick(2);
        Reset = 1'b0;
    endtask

    task automatic load(input logic [7:0] a, b, c, d);
        foreach (rom[i]) rom[i] = 8'h00;
        rom[0] = a; rom[1] = b; rom[2] = c; rom[3] = d;
    endtask

    task automatic wait_n(input string name, input int n, input int budget);
        int c = 0;
        while (lg.size() < n && c < budget) begin
            tick(1);
            c++;
        end
        chk(name, lg.size(), n);
    endtask

    task automatic wait_valid(input string name, input int budget);
        int c = 0;
        while (!bus.din_valid && c < budget) begin
            tick(1);
            c++;
        end
        chk(name, bus.din_valid, 1);
    endtask

    // model: the next word comes from m_pc; a word is an immediate iff the previous delivered word was a non-immediate mvi
    initial forever begin
        @(negedge Clock);
        if (armed) begin
            chk("pc", PC, m_pc);
            chk("done", Done, m_done);
            if (m_done) chk("valid_in_halt", bus.din_valid, 0);
            if (bus.din_valid) begin
                chk("din", bus.DIN, rom[m_pc]);
                chk("imm", bus.Imm, m_imm);
            end
        end
        if (Reset) begin
            armed = 1; m_pc = 0; m_imm = 0; m_done = 0;
            lg.delete();
        end else if (armed && bus.din_valid && bus.din_ready) begin
            lg.push_back({bus.Imm, bus.DIN});
            m_imm = !m_imm && rom[m_pc][7:6] == 2'b01;
            if (m_pc == PL - 1) begin
                if (WRAP) m_pc = 0;
                else m_done = 1;
            end else m_pc++;
        end
    end

    initial begin
        int c;
        bus.din_ready = 1'b0;
        load(8'h40, 8'h05, 8'h41, 8'h07);
        do_reset();
        chk("rst_rom_addr", bus.rom_addr, 0);
        chk("rst_din", bus.DIN, 0);
        chk("rst_valid", bus.din_valid, 0);
        chk("rst_imm", bus.Imm, 0);
        chk("rst_pc", PC, 0);
        chk("rst_done", Done, 0);

        // free run: latency, sequence, end of program
        bus.din_ready = 1'b1;
        Run = 1'b1;
        c = 0;
        while (!bus.din_valid && c < 10) begin
            tick(1);
            c++;
        end
        chk("latency", c, 3);
        wait_n("t1_count", 4, 40);
        chk("t1_w0", lg[0], 9'h040);
        chk("t1_w1", lg[1], 9'h105);
        chk("t1_w2", lg[2], 9'h041);
        chk("t1_w3", lg[3], 9'h107);
        if (WRAP) begin
            wait_n("t1_wrap_count", 5, 20);
            chk("t1_wrap_w4", lg[4], 9'h040);
            chk("t1_wrap_done", Done, 0);
        end else begin
            tick(5);
            chk("t1_done", Done, 1);
            chk("t1_halt_valid", bus.din_valid, 0);
            chk("t1_halt_pc", PC, 3);
        end
        Run = 1'b0;
        tick(6);

        // immediate that looks like mvi is not decoded
        do_reset();
        load(8'h40, 8'h40, 8'h00, 8'h00);
        Run = 1'b1;
        wait_n("t2_count", 3, 30);
        Run = 1'b0;
        chk("t2_w0", lg[0], 9'h040);
        chk("t2_w1", lg[1], 9'h140);
        chk("t2_w2", lg[2], 9'h000);
        tick(8);

        // single step
        do_reset();
        load(8'h10, 8'h20, 8'h30, 8'h40);
        for (int i = 0; i < 3; i++) begin
            Step = 1'b1;
            tick(2);
            Step = 1'b0;
            wait_n("t3_step", i + 1, 20);
            tick(3);
        end
        tick(4);
        chk("t3_count", lg.size(), 3);
        chk("t3_pc", PC, 3);
        chk("t3_idle", bus.din_valid, 0);
        chk("t3_w1", lg[1], 9'h020);

        // stall in PRESENT with an ignored step edge
        bus.din_ready = 1'b0;
        Step = 1'b1;
        tick(2);
        Step = 1'b0;
        wait_valid("t4_present", 20);
        Step = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i == 2) Step = 1'b0;
            chk("t4_hold_din", bus.DIN, 8'h40);
            chk("t4_hold_imm", bus.Imm, 0);
            chk("t4_hold_pc", PC, 3);
            chk("t4_hold_valid", bus.din_valid, 1);
            tick(1);
        end
        bus.din_ready = 1'b1;
        tick(15);
        chk("t4_count", lg.size(), 4);
        chk("t4_w3", lg[3], 9'h040);

        // reset during CAP aborts the word
        do_reset();
        load(8'h40, 8'h05, 8'h41, 8'h07);
        Run = 1'b1;
        tick(2);
        Reset = 1'b1;
        Run = 1'b0;
        tick(1);
        chk("t5_rom_addr", bus.rom_addr, 0);
        chk("t5_din", bus.DIN, 0);
        chk("t5_valid", bus.din_valid, 0);
        chk("t5_imm", bus.Imm, 0);
        chk("t5_pc", PC, 0);
        chk("t5_done", Done, 0);
        Reset = 1'b0;
        tick(1);
        chk("t5_none", lg.size(), 0);
        Run = 1'b1;
        wait_n("t5_count", 1, 20);
        chk("t5_w0", lg[0], 9'h040);
        Run = 1'b0;
        tick(6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
